// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Purpose  : 16/8 unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        dbz
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_dvd;
   logic [7:0]  r_dvs;
   logic [7:0]  r_rem;
   logic [15:0] r_qwork;
   logic [3:0]  r_cnt;

   logic        w_accept;
   logic        w_last;
   logic [8:0]  w_trial;
   logic        w_ge;
   logic [7:0]  w_sub;
   logic [7:0]  w_rem_nxt;

   assign w_accept  = start && (r_state != S_RUN);
   assign w_last    = (r_cnt == 4'd15);
   assign w_trial   = {r_rem, r_dvd[15]};
   assign w_ge      = (w_trial >= {1'b0, r_dvs});
   // When the subtraction is taken the true difference is < divisor, so the
   // low eight bits of a modular subtract are exact.
   assign w_sub     = w_trial[7:0] - r_dvs;
   assign w_rem_nxt = w_ge ? w_sub : w_trial[7:0];

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = (divisor == 8'd0) ? S_DONE : S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dvd     <= 16'd0;
         r_dvs     <= 8'd0;
         r_rem     <= 8'd0;
         r_qwork   <= 16'd0;
         r_cnt     <= 4'd0;
         quotient  <= 16'd0;
         remainder <= 8'd0;
         dbz       <= 1'b0;
      end else if (w_accept) begin
         r_dvd   <= dividend;
         r_dvs   <= divisor;
         r_rem   <= 8'd0;
         r_qwork <= 16'd0;
         r_cnt   <= 4'd0;
         // Divide-by-zero skips RUN, so its result is published right away.
         if (divisor == 8'd0) begin
            quotient  <= 16'hFFFF;
            remainder <= 8'd0;
            dbz       <= 1'b1;
         end
      end else if (r_state == S_RUN) begin
         r_dvd   <= {r_dvd[14:0], 1'b0};
         r_rem   <= w_rem_nxt;
         r_qwork <= {r_qwork[14:0], w_ge};
         r_cnt   <= r_cnt + 4'd1;
         if (w_last) begin
            quotient  <= {r_qwork[14:0], w_ge};
            remainder <= w_rem_nxt;
            dbz       <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
Parameters: none; all widths are fixed.
REQ-001 clk  input  1  Single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  Asynchronous, active-low reset.
REQ-003 start  input  1  Request a division; sampled only when the block is ready to accept.
REQ-004 dividend  input  16  Unsigned dividend; sampled with start.
REQ-005 divisor  input  8  Unsigned divisor; sampled with start.
REQ-006 busy  output  1  High while a division is in progress.
REQ-007 done  output  1  Single-cycle pulse when the results are valid.
REQ-008 quotient  output  16  Unsigned quotient; held until the next accepted start.
REQ-009 remainder  output  8  Unsigned remainder; held until the next accepted start.
REQ-010 dbz  output  1  Divide-by-zero flag for the last completed operation; held like quotient.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted.
- The block latches dividend and divisor and clears the working remainder.
- The step counter is set to 0.
- The FSM goes to RUN, or to DONE on divide-by-zero.
REQ-013 In RUN, start SHALL be ignored: operands are not resampled and there is no error.
REQ-014 In RUN, each cycle SHALL perform one restoring shift-subtract step, MSB of the dividend first.
- Form a 9-bit trial value t = {working remainder[7:0], next dividend bit}.
- If t >= divisor: working remainder = t - divisor and the quotient bit = 1.
- Otherwise: working remainder = t and the quotient bit = 0.
REQ-015 The working remainder SHALL be 9 bits internally; the value stored after each step is always < divisor, so it fits in 8 bits.
REQ-016 RUN SHALL last exactly 16 cycles, with the counter going 0..15; after the step with counter = 15 the FSM goes to DONE.
REQ-017 Latency: for start accepted at edge N, done SHALL be high in the cycle after edge N+16, with quotient and remainder already valid in that cycle.
REQ-018 DONE SHALL last one cycle.
- done = 1 and busy = 0 in DONE.
- DONE goes to IDLE, or to RUN if start = 1 in that cycle (back-to-back operation).
REQ-019 busy SHALL equal 1 exactly when the state is RUN.
REQ-020 Divide-by-zero (divisor = 0 at start) SHALL skip RUN.
- DONE follows on the next edge, so done is high in the cycle after the accepting edge.
- dbz = 1, quotient = 16'hFFFF, remainder = 8'h00.
REQ-021 For every non-zero divisor, the result SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor, with dbz = 0.
REQ-022 quotient, remainder and dbz SHALL only change on entry to DONE; in IDLE and RUN they hold the previous result.
REQ-023 quotient bits not yet computed SHALL NOT be visible on the quotient output during RUN; use a separate working register.
REQ-024 For divisor = 1, quotient SHALL equal dividend, including 16'hFFFF with no overflow; no operand pair overflows the 16-bit quotient.

Reset
REQ-025 rst_n = 0 SHALL immediately, without waiting for a clock edge, force:
- the state to IDLE;
- busy = 0 and done = 0;
- quotient = 0, remainder = 0, dbz = 0;
- all working registers and the counter to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; a start after reset release SHALL run a full 16-cycle division.
REQ-027 The first rising edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-028 dividend=1000, divisor=7, start for 1 cycle -> busy for 16 cycles, then done=1 with quotient=142, remainder=6, dbz=0.
REQ-029 dividend=65025, divisor=255 -> quotient=255, remainder=0; then dividend=65535, divisor=1 -> quotient=65535, remainder=0.
REQ-030 dividend=5, divisor=0 -> done in the cycle after the accepting edge, dbz=1, quotient=16'hFFFF, remainder=0, busy never high.
REQ-031 start with 100/3; at RUN cycle 5, present start with 9/9 -> the second start is ignored; result is quotient=33, remainder=1.
REQ-032 start with 1000/7; drop rst_n at RUN cycle 8 -> outputs are 0 immediately with no done pulse; after release, 200/9 -> quotient=22, remainder=2.
REQ-033 start held high continuously with 300/17 -> done pulses every 17 cycles, each with quotient=17, remainder=11.
- Formal checks: REQ-021 on every done; busy and done never both high; REQ-022 output hold.
